mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 The block SHALL have parameter ILLEGAL_HALT, default 1; 1 = illegal opcode/funct enters HALT, 0 = treated as NOP and control returns to FETCH.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port funct, input, 6, instruction bits [5:0].
REQ-006 The block SHALL have port zero, input, 1, ALU zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1, memory access-complete handshake.
REQ-008 The block SHALL have outputs mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a, ext_sel, halted (1 bit each), plus alu_src_b (2 bits), pc_src (2 bits), alu_ctrl (3 bits) and state (4 bits).
REQ-009 ext_sel SHALL select the immediate extender mode: 1 = sign-extend 16->32, 0 = zero-extend.

Function
REQ-010 Supported instructions SHALL be: R-type (000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; beq 000100; bne 000101; addi 001000; andi 001100; ori 001101; j 000010.
REQ-011 alu_ctrl encodings SHALL be: add 010, sub 110, and 000, or 001, slt 111.
REQ-012 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, HALT, encoded 0-12 in that order and driven on the state output.
REQ-013 FETCH SHALL hold mem_req=1 and mem_we=0 until mem_ready=1; in the cycle mem_ready=1 it SHALL assert ir_write=1, pc_write=1 with pc_src=00 (PC+4), then go to DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11 (sign-extended immediate shifted left 2) and alu_ctrl=add (branch target precompute), then dispatch on opcode: R-type to EXEC_R; lw/sw to MEM_ADDR; addi/andi/ori to EXEC_I; beq/bne to BRANCH; j to JUMP; anything else per REQ-022.
REQ-015 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00 and alu_ctrl from funct, then go to WB_R; WB_R SHALL pulse reg_write=1 with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-016 EXEC_I SHALL drive alu_src_b=10 with ext_sel=1 for addi and ext_sel=0 for andi/ori, alu_ctrl add/and/or respectively, then go to WB_I; WB_I SHALL pulse reg_write=1 with reg_dst=0 and mem_to_reg=0.
REQ-017 MEM_ADDR SHALL drive ext_sel=1, alu_src_b=10 and alu_ctrl=add, then go to MEM_RD for lw or MEM_WR for sw.
REQ-018 MEM_RD and MEM_WR SHALL hold mem_req=1 (mem_we=1 only in MEM_WR) until mem_ready=1; MEM_RD then goes to WB_MEM, which pulses reg_write=1 with mem_to_reg=1 and reg_dst=0; MEM_WR then goes to FETCH.
REQ-019 BRANCH SHALL drive alu_ctrl=sub and pc_src=01, and assert pc_write iff (beq and zero=1) or (bne and zero=0), then go to FETCH.
REQ-020 JUMP SHALL assert pc_write=1 with pc_src=10, then go to FETCH.
REQ-021 Latency with mem_ready tied high SHALL be: R-type and I-ALU 4 cycles, lw 5, sw 4, branch 3, j 3; each wait cycle on mem_ready adds exactly one cycle.
REQ-022 An illegal opcode or funct SHALL go to HALT when ILLEGAL_HALT=1, otherwise to FETCH with no register or PC write.
REQ-023 HALT SHALL be absorbing: halted=1, all strobes 0, and it is exited only by rst.
REQ-024 mem_ready SHALL be ignored in every state except FETCH, MEM_RD and MEM_WR.
REQ-025 All strobe outputs (mem_req, mem_we, ir_write, pc_write, reg_write) SHALL be 0 in any state not listed as asserting them; mux selects not specified for a state SHALL be 0.

Reset
REQ-026 rst=1 at a clock edge SHALL force state FETCH from any state, including mid-wait in a memory state and HALT.
REQ-027 While rst=1, all outputs SHALL be 0 except state, which SHALL read FETCH (0).
REQ-028 The first mem_req SHALL be asserted in the first cycle after rst deasserts.

Structure
REQ-029 State encodings, opcode/funct constants and alu_ctrl codes SHALL reside in a shared package, mips_pkg, reused by the datapath.
REQ-030 The block SHALL consist of one registered state FSM with combinational output decode, plus one sub-module, alu_decoder, mapping opcode/funct to alu_ctrl and an illegal flag.

Verification
REQ-031 add (funct 100000), mem_ready=1 -> states 0,1,2,7,0; reg_write=1 only in WB_R with reg_dst=1; alu_ctrl=010 in EXEC_R.
REQ-032 lw with mem_ready low for 3 cycles in MEM_RD -> 8 cycles in total; mem_req held high throughout; reg_write=1 with mem_to_reg=1 in WB_MEM.
REQ-033 beq with zero=1 -> pc_write=1 and pc_src=01 in BRANCH; bne with zero=1 -> pc_write=0.
REQ-034 ori -> ext_sel=0 and alu_ctrl=001 in EXEC_I; addi -> ext_sel=1 and alu_ctrl=010.
REQ-035 opcode 111111 with ILLEGAL_HALT=1 -> HALT and halted=1 held for 20 cycles; rst=1 -> FETCH on the next edge.
REQ-036 rst asserted during a MEM_WR wait -> state 0 on the next edge, mem_we=0, no reg_write or pc_write pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path and datapath:
// FSM states, opcode/funct constants, ALU control codes and mux selects.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_R     = 4'd7,
      S_WB_I     = 4'd8,
      S_WB_MEM   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select: register, constant 4, immediate, immediate << 2
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mips_mc_ctrl_alu_decoder.sv
// Maps opcode/funct to the ALU operation and flags instructions the core does not implement.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       illegal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: illegal  = 1'b1;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI, OP_J: alu_ctrl = ALU_ADD;
         OP_BEQ, OP_BNE:              alu_ctrl = ALU_SUB;
         OP_ANDI:                     alu_ctrl = ALU_AND;
         OP_ORI:                      alu_ctrl = ALU_OR;
         default:                     illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: registered state FSM with combinational output decode.
// While rst is high every output is forced low and state reads FETCH.
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int ILLEGAL_HALT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic       ext_sel,
   output logic       halted,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_ctrl,
   output logic [3:0] state
);

   state_e     state_q, state_d;
   logic [2:0] dec_alu_ctrl;
   logic       dec_illegal;

   alu_decoder u_alu_decoder (
      .opcode   (opcode),
      .funct    (funct),
      .alu_ctrl (dec_alu_ctrl),
      .illegal  (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (dec_illegal) begin
               state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
            end else begin
               case (opcode)
                  OP_RTYPE:                  state_d = S_EXEC_R;
                  OP_LW, OP_SW:              state_d = S_MEM_ADDR;
                  OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
                  OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                  OP_J:                      state_d = S_JUMP;
                  default:                   state_d = S_FETCH;
               endcase
            end
         end
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   assign state = rst ? S_FETCH : state_q;

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      ext_sel    = 1'b0;
      halted     = 1'b0;
      alu_src_b  = SRCB_REG;
      pc_src     = PCSRC_SEQ;
      alu_ctrl   = 3'b000;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
               pc_src   = PCSRC_SEQ;
            end
            // Branch target is precomputed here while the register file is read
            S_DECODE: begin
               alu_src_b = SRCB_IMM_SH;
               alu_ctrl  = ALU_ADD;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_ctrl  = dec_alu_ctrl;
            end
            S_EXEC_I: begin
               alu_src_b = SRCB_IMM;
               ext_sel   = (opcode == OP_ADDI);
               alu_ctrl  = dec_alu_ctrl;
            end
            S_MEM_ADDR: begin
               ext_sel   = 1'b1;
               alu_src_b = SRCB_IMM;
               alu_ctrl  = ALU_ADD;
            end
            S_MEM_RD: mem_req = 1'b1;
            S_MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
            end
            S_WB_R: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_WB_I:   reg_write = 1'b1;
            S_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
               alu_ctrl = ALU_SUB;
               pc_src   = PCSRC_BR;
               pc_write = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = PCSRC_JUMP;
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: random instruction stream with random memory stalls,
// checked cycle by cycle against an instruction-level state-path and output table.
module tb_mips_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst;
   logic       mem_to_reg, alu_src_a, ext_sel, halted;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_ctrl;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;
   int zforce = -1;

   always #5 clk = ~clk;

   mips_mc_ctrl #(.ILLEGAL_HALT(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .ext_sel    (ext_sel),
      .halted     (halted),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_ctrl   (alu_ctrl),
      .state      (state)
   );

   wire [16:0] obs_vec = {mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst, mem_to_reg,
                          alu_src_a, ext_sel, halted, alu_src_b, pc_src, alu_ctrl};

   // Instruction kinds: 0 add 1 sub 2 and 3 or 4 slt 5 lw 6 sw 7 beq 8 bne
   // 9 addi 10 andi 11 ori 12 j 13 random illegal opcode 14 illegal funct 15 opcode 111111
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] exp_vec(input int s, input int kind, input logic mr, input logic z);
      logic mreq = 0, mwe = 0, irw = 0, pcw = 0, rw = 0, rdst = 0, m2r = 0;
      logic srca = 0, ext = 0, hlt = 0;
      logic [1:0] srcb = 0, psrc = 0;
      logic [2:0] alu = 0;
      case (s)
         0: begin mreq = 1; irw = mr; pcw = mr; end
         1: begin srcb = 2'b11; alu = 3'b010; end
         2: begin
            srca = 1;
            case (kind)
               0: alu = 3'b010;
               1: alu = 3'b110;
               2: alu = 3'b000;
               3: alu = 3'b001;
               default: alu = 3'b111;
            endcase
         end
         3: begin
            srcb = 2'b10;
            ext  = (kind == 9);
            alu  = (kind == 9) ? 3'b010 : (kind == 10) ? 3'b000 : 3'b001;
         end
         4: begin ext = 1; srcb = 2'b10; alu = 3'b010; end
         5: mreq = 1;
         6: begin mreq = 1; mwe = 1; end
         7: begin rw = 1; rdst = 1; end
         8: rw = 1;
         9: begin rw = 1; m2r = 1; end
         10: begin alu = 3'b110; psrc = 2'b01; pcw = (kind == 7 && z) || (kind == 8 && !z); end
         11: begin pcw = 1; psrc = 2'b10; end
         12: hlt = 1;
         default: ;
      endcase
      return {mreq, mwe, irw, pcw, rw, rdst, m2r, srca, ext, hlt, srcb, psrc, alu};
   endfunction

   task automatic pick(input int kind, output logic [5:0] op, output logic [5:0] fn);
      logic [5:0] r_fn [0:4];
      r_fn[0] = 6'b100000; r_fn[1] = 6'b100010; r_fn[2] = 6'b100100;
      r_fn[3] = 6'b100101; r_fn[4] = 6'b101010;
      fn = 6'($urandom_range(0, 63));
      case (kind)
         0, 1, 2, 3, 4: begin op = 6'b000000; fn = r_fn[kind]; end
         5:  op = 6'b100011;
         6:  op = 6'b101011;
         7:  op = 6'b000100;
         8:  op = 6'b000101;
         9:  op = 6'b001000;
         10: op = 6'b001100;
         11: op = 6'b001101;
         12: op = 6'b000010;
         13: begin
            op = 6'($urandom_range(0, 63));
            while (op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43})
               op = 6'($urandom_range(0, 63));
         end
         14: begin
            op = 6'b000000;
            while (fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42})
               fn = 6'($urandom_range(0, 63));
         end
         default: op = 6'b111111;
      endcase
   endtask

   task automatic step(input int s, input int kind, input logic mr);
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = mr;
      zero      = (zforce >= 0) ? zforce[0] : 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("state kind%0d", kind), 32'(state), 32'(s));
      chk($sformatf("outs kind%0d st%0d", kind, s), 32'(obs_vec), 32'(exp_vec(s, kind, mr, zero)));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst       = 1'b1;
         mem_ready = 1'($urandom_range(0, 1));
         zero      = 1'($urandom_range(0, 1));
         #1;
         chk("rst_state", 32'(state), 32'd0);
         chk("rst_outs", 32'(obs_vec), 32'd0);
      end
   endtask

   task automatic run_instr(input int kind, input int rd_wait, input int halt_n);
      logic [5:0] op, fn;
      int path[$];
      int s, waits, cyc;
      logic is_mem;
      cyc = 0;
      pick(kind, op, fn);
      opcode = op;
      funct  = fn;
      path.push_back(0);
      path.push_back(1);
      case (kind)
         0, 1, 2, 3, 4: begin path.push_back(2); path.push_back(7); end
         5:  begin path.push_back(4); path.push_back(5); path.push_back(9); end
         6:  begin path.push_back(4); path.push_back(6); end
         7, 8: path.push_back(10);
         9, 10, 11: begin path.push_back(3); path.push_back(8); end
         12: path.push_back(11);
         default: path.push_back(12);
      endcase
      foreach (path[k]) begin
         s      = path[k];
         is_mem = (s == 0 || s == 5 || s == 6);
         waits  = 0;
         if (is_mem) waits = (s == 5 && rd_wait >= 0) ? rd_wait : $urandom_range(0, 2);
         for (int w = 0; w <= waits; w++) begin
            step(s, kind, is_mem ? (w == waits) : 1'($urandom_range(0, 1)));
            cyc++;
         end
      end
      if (s == 12) begin
         for (int h = 0; h < halt_n; h++) begin
            step(12, kind, 1'($urandom_range(0, 1)));
            cyc++;
         end
         do_reset(1);
      end
      $display("instr kind=%0d opcode=%b funct=%b cycles=%0d", kind, op, fn, cyc);
   endtask

   initial begin
      do_reset(3);

      run_instr(0, -1, 0);
      run_instr(5, 3, 0);
      zforce = 1;
      run_instr(7, -1, 0);
      run_instr(8, -1, 0);
      zforce = 0;
      run_instr(7, -1, 0);
      run_instr(8, -1, 0);
      zforce = -1;
      run_instr(11, -1, 0);
      run_instr(9, -1, 0);
      run_instr(15, -1, 20);

      // Reset while a store waits on memory
      opcode = 6'b101011;
      funct  = 6'd0;
      step(0, 6, 1'b1);
      step(1, 6, 1'b0);
      step(4, 6, 1'b1);
      step(6, 6, 1'b0);
      step(6, 6, 1'b0);
      do_reset(1);
      step(0, 6, 1'b0);
      $display("instr sw aborted by reset");

      for (int i = 0; i < 80; i++) run_instr($urandom_range(0, 15), -1, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
